idst4_seq: RTL and testbench



---
 rtl/idst4_seq.sv | 138 +++++++++++++
 tb/tb_idst4_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/idst4_seq.sv
// Sequential 4-point inverse DST: collects 4 coefficients, then produces each residual
// with one shared signed MAC followed by round-half-up, arithmetic shift and saturation.
module idst4_seq #(
    parameter int IN_W    = 16,
    parameter int COEFF_W = 8,
    parameter int SHIFT   = 7,
    parameter int OUT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);
    // Handshakes: a word moves on a rising edge where valid && ready; out_valid,
    // once high, stays high with stable out_data until that edge.
    localparam int ACC_W  = IN_W + COEFF_W + 2;
    localparam int PROD_W = IN_W + COEFF_W;
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (SHIFT - 1);
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {S_LOAD, S_CALC, S_ROUND, S_OUT} state_t;

    state_t                   state, state_next;
    logic                     live;
    logic [1:0]               idx_i, idx_j, idx_k;
    logic signed [IN_W-1:0]   d_mem [4];
    logic signed [ACC_W-1:0]  acc;
    logic signed [COEFF_W-1:0] coef;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  rnd_sum, rnd;
    logic [OUT_W-1:0]         sat;

    // Inverse matrix entry T[k][j]: row = output index, column = input index.
    always_comb begin
        coef = '0;
        case ({idx_k, idx_j})
            4'h0: coef = COEFF_W'(29);
            4'h1: coef = COEFF_W'(74);
            4'h2: coef = COEFF_W'(84);
            4'h3: coef = COEFF_W'(55);
            4'h4: coef = COEFF_W'(55);
            4'h5: coef = COEFF_W'(74);
            4'h6: coef = COEFF_W'(-29);
            4'h7: coef = COEFF_W'(-84);
            4'h8: coef = COEFF_W'(74);
            4'h9: coef = COEFF_W'(0);
            4'hA: coef = COEFF_W'(-74);
            4'hB: coef = COEFF_W'(74);
            4'hC: coef = COEFF_W'(84);
            4'hD: coef = COEFF_W'(-74);
            4'hE: coef = COEFF_W'(55);
            4'hF: coef = COEFF_W'(-29);
            default: coef = '0;
        endcase
    end

    always_comb begin
        prod    = PROD_W'(d_mem[idx_j]) * PROD_W'(coef);
        rnd_sum = acc + HALF;
        rnd     = rnd_sum >>> SHIFT;
        if (rnd > MAXV)
            sat = MAXV[OUT_W-1:0];
        else if (rnd < MINV)
            sat = MINV[OUT_W-1:0];
        else
            sat = rnd[OUT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_LOAD;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_LOAD:  if (in_valid && in_ready && idx_i == 2'd3) state_next = S_CALC;
            S_CALC:  if (idx_j == 2'd3) state_next = S_ROUND;
            S_ROUND: state_next = S_OUT;
            S_OUT:   if (out_ready) state_next = (idx_k == 2'd3) ? S_LOAD : S_CALC;
            default: state_next = S_LOAD;
        endcase
    end

    // live keeps in_ready low while rst is held, even though state already reads LOAD.
    always_comb begin
        in_ready  = live && (state == S_LOAD);
        out_valid = (state == S_OUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live     <= 1'b0;
            idx_i    <= '0;
            idx_j    <= '0;
            idx_k    <= '0;
            acc      <= '0;
            out_data <= '0;
            for (int n = 0; n < 4; n++) d_mem[n] <= '0;
        end else begin
            live <= 1'b1;
            case (state)
                S_LOAD: begin
                    if (in_valid && in_ready) begin
                        d_mem[idx_i] <= in_data;
                        idx_i        <= idx_i + 2'd1;
                        if (idx_i == 2'd3) begin
                            idx_i <= '0;
                            idx_j <= '0;
                            idx_k <= '0;
                            acc   <= '0;
                        end
                    end
                end
                S_CALC: begin
                    acc   <= acc + ACC_W'(prod);
                    idx_j <= idx_j + 2'd1;
                end
                S_ROUND: out_data <= sat;
                S_OUT: begin
                    if (out_ready) begin
                        acc   <= '0;
                        idx_j <= '0;
                        idx_k <= idx_k + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_idst4_seq.sv
// Randomized scoreboard bench for idst4_seq: expected residuals come from a
// matrix-times-vector reference model; a negedge monitor pops and compares.
module tb_idst4_seq;
    localparam int IN_W  = 16;
    localparam int OUT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_data;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;
    logic [OUT_W-1:0] exp_q[$];

    int tmat [4][4] = '{'{29, 74, 84, 55}, '{55, 74, -29, -84},
                        '{74, 0, -74, 74}, '{84, -74, 55, -29}};

    idst4_seq #(.IN_W(IN_W), .COEFF_W(8), .SHIFT(7), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic timeout_fail(input string name);
        chk_cnt++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    // reference model: r = sat(floor((T*d + 64) / 128))
    function automatic longint ref_out(input longint dv [4], input int k);
        longint s = 0;
        longint q;
        for (int j = 0; j < 4; j++) s += dv[j] * tmat[k][j];
        q = (s + 64) >>> 7;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return q;
    endfunction

    // driver tasks
    task automatic push_word(input int w);
        int n = 0;
        in_valid = 1'b1;
        in_data  = 16'(w);
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) timeout_fail("in_handshake");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_block(input int d0, input int d1, input int d2, input int d3,
                              input bit gap);
        longint dv [4];
        int dw [4];
        dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
        dw[0] = d0; dw[1] = d1; dw[2] = d2; dw[3] = d3;
        for (int k = 0; k < 4; k++) exp_q.push_back(OUT_W'(ref_out(dv, k)));
        for (int i = 0; i < 4; i++) begin
            push_word(dw[i]);
            if (gap && i < 3) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // stall_k >= 0: hold out_ready low for stall_len valid cycles on output stall_k;
    // rnd_ready: random out_ready; junk: random in_valid pulses while the block is busy.
    task automatic run_outputs(input int stall_k, input int stall_len, input bit rnd_ready,
                               input bit junk, input int n_out);
        int done = 0;
        int n    = 0;
        int sc   = 0;
        while (done < n_out && n < 3000) begin
            if (rnd_ready) out_ready = ($urandom_range(0, 1) == 1);
            else if (done == stall_k && out_valid && sc < stall_len) begin
                out_ready = 1'b0;
                sc++;
            end else out_ready = 1'b1;
            in_valid = junk && (done < 3) && ($urandom_range(0, 1) == 1);
            in_data  = 16'($urandom);
            @(negedge clk);
            if (out_valid && out_ready) done++;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (done < n_out) timeout_fail("out_handshake");
    endtask

    // scoreboard monitor
    initial begin : monitor
        int in_cnt = 0, out_cnt = 0, ref_cyc = 0;
        bit busy = 0, prev_stall = 0, prev_valid = 0;
        logic [OUT_W-1:0] prev_data = '0;
        logic [OUT_W-1:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_cnt = 0; out_cnt = 0; busy = 0; prev_stall = 0; prev_valid = 0;
                continue;
            end
            if (prev_stall) begin
                check("stall_valid_held", out_valid, 1);
                check("stall_data_held", out_data, prev_data);
            end
            if (out_valid && !prev_valid) check("out_latency", cyc - ref_cyc, 5);
            if (busy) check("in_ready_low_busy", in_ready, 0);
            if (in_valid && in_ready) begin
                in_cnt++;
                if (in_cnt == 4) begin
                    in_cnt = 0; busy = 1; out_cnt = 0; ref_cyc = cyc + 1;
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL unexpected_output: got %0d, expected none", $signed(out_data));
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", longint'($signed(out_data)), longint'($signed(e)));
                end
                ref_cyc = cyc + 1;
                out_cnt++;
                if (out_cnt == 4) busy = 0;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_valid = out_valid;
        end
    end

    initial begin : stimulus
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_release", in_ready, 1);

        send_block(64, 0, 0, 0, 0);
        run_outputs(-1, 0, 0, 0, 4);
        send_block(0, 128, 0, 0, 0);
        run_outputs(-1, 0, 0, 0, 4);
        send_block(32767, 32767, 32767, 32767, 0);
        run_outputs(-1, 0, 0, 0, 4);
        send_block(-32768, -32768, -32768, -32768, 0);
        run_outputs(-1, 0, 0, 0, 4);

        // backpressure on r[1] with ignored in_valid pulses
        send_block(64, 0, 0, 0, 0);
        run_outputs(1, 10, 0, 1, 4);

        // gapped input, then two back-to-back blocks
        send_block(10, -20, 30, -40, 1);
        run_outputs(-1, 0, 0, 0, 4);
        send_block(-1000, 2500, -3333, 777, 0);
        run_outputs(-1, 0, 0, 0, 4);
        send_block(int'($urandom_range(0, 65535)) - 32768, 5, -5, 12345, 1);
        run_outputs(-1, 0, 0, 0, 4);

        // reset during CALC of the second output
        send_block(64, 0, 0, 0, 0);
        run_outputs(-1, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_data", out_data, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_block(64, 0, 0, 0, 0);
        run_outputs(-1, 0, 0, 0, 4);

        // randomized blocks with random backpressure and junk input pulses
        for (int b = 0; b < 8; b++) begin
            send_block(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                       int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                       bit'($urandom_range(0, 1)));
            run_outputs(-1, 0, 1, 1, 4);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        // final report
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
